// File: rtl/regwb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regwb_pkg
// Description : Shared types and constants for the register-file writeback
//               arbiter: index/data widths, register count and the
//               write-port stage record.
// Revision    : 1.0 - initial release
// ============================================================================
package regwb_pkg;

    localparam int AW       = 3;
    localparam int DW       = 16;
    localparam int NREGS    = 1 << AW;
    localparam int NREQ_MAX = 4;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] reg_data_t;

    // One registered register-file write port.
    typedef struct packed {
        logic      we;
        reg_idx_t  idx;
        reg_data_t data;
    } wb_port_t;

endpackage : regwb_pkg
`default_nettype wire

// File: rtl/regwb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : regwb_rr_pick
// Description : Combinational round-robin double picker. Scans requesters
//               starting at rr_i (wrapping modulo NREQ). The first active
//               requester becomes pick 1; the next active requester whose
//               destination differs from pick 1's becomes pick 2.
// Ports       : req_i   - per-requester request
//               dest_i  - packed destinations, requester i at [i*AW +: AW]
//               rr_i    - scan start index
//               pick1_o / pick2_o - one-hot winners
//               vld1_o  / vld2_o  - winner present
// Revision    : 1.0 - initial release
// ============================================================================
module regwb_rr_pick #(
    parameter int NREQ = 3,
    parameter int AW   = 3,
    parameter int RRW  = 2
) (
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*AW-1:0] dest_i,
    input  logic [RRW-1:0]     rr_i,
    output logic [NREQ-1:0]    pick1_o,
    output logic [NREQ-1:0]    pick2_o,
    output logic               vld1_o,
    output logic               vld2_o
);
    import regwb_pkg::*;

    logic [AW-1:0] w_dest1;

    // Outer loop walks scan positions in priority order; inner loop finds the
    // requester sitting at that position, so every index stays a constant.
    always_comb begin
        int pos;
        pick1_o = '0;
        pick2_o = '0;
        vld1_o  = 1'b0;
        vld2_o  = 1'b0;
        w_dest1 = '0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                pos = j - int'(rr_i);
                if (pos < 0) begin
                    pos = pos + NREQ;
                end
                if (pos == k && req_i[j]) begin
                    if (!vld1_o) begin
                        pick1_o[j] = 1'b1;
                        vld1_o     = 1'b1;
                        w_dest1    = dest_i[j*AW +: AW];
                    end else if (!vld2_o && (dest_i[j*AW +: AW] != w_dest1)) begin
                        // Same-dest requesters are skipped so both ports
                        // never target one register on the same edge.
                        pick2_o[j] = 1'b1;
                        vld2_o     = 1'b1;
                    end
                end
            end
        end
    end

endmodule : regwb_rr_pick
`default_nettype wire

// File: rtl/regwb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regwb_arbiter
// Description : Writeback arbiter and pending-write scoreboard for the 8x16
//               two-write-port register file. Grants up to two requesters per
//               cycle, drives the file's write ports from registered stages
//               and tracks registers with an outstanding producer.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req_i/req_dest_i/req_data_i - writeback requests
//               gnt_o               - combinational grant (consumes request)
//               cw*_o/cs*_o/cd*_o   - registered register-file write ports
//               wt1_i/wt2_i         - register-file wait (holds everything)
//               sb_set_i/sb_set_reg_i - mark a destination pending
//               sb_busy_o/sb_dup_o  - pending bits, sticky double-set flag
//               conflict_cnt_o/conflict_clr_i - only with the option below
// Options     : REGWB_CONFLICT_CNT_EN adds a saturating 16-bit counter of
//               non-stalled cycles that left an active request ungranted.
// Note        : AW/DW must match the regwb_pkg constants (port records).
// Revision    : 1.0 - initial release
// ============================================================================
module regwb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   req_dest_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 cw1_o,
    output logic                 cw2_o,
    output logic [AW-1:0]        cs1_o,
    output logic [AW-1:0]        cs2_o,
    output logic [DW-1:0]        cd1_o,
    output logic [DW-1:0]        cd2_o,
    input  logic                 wt1_i,
    input  logic                 wt2_i,
    input  logic                 sb_set_i,
    input  logic [AW-1:0]        sb_set_reg_i,
    output logic [(1<<AW)-1:0]   sb_busy_o,
    output logic                 sb_dup_o
`ifdef REGWB_CONFLICT_CNT_EN
    ,
    output logic [15:0]          conflict_cnt_o,
    input  logic                 conflict_clr_i
`endif
);
    import regwb_pkg::*;

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NR  = 1 << AW;

    logic [NREQ-1:0] w_pick1, w_pick2;
    logic            w_vld1, w_vld2;
    logic            w_stall;

    logic [RRW-1:0]  rr_q, rr_d;
    wb_port_t        port1_q, port1_d, port2_q, port2_d;
    logic [NR-1:0]   busy_q, busy_d;
    logic            dup_q, dup_d;

    regwb_rr_pick #(
        .NREQ (NREQ),
        .AW   (AW),
        .RRW  (RRW)
    ) u_pick (
        .req_i   (req_i),
        .dest_i  (req_dest_i),
        .rr_i    (rr_q),
        .pick1_o (w_pick1),
        .pick2_o (w_pick2),
        .vld1_o  (w_vld1),
        .vld2_o  (w_vld2)
    );

    assign w_stall = wt1_i | wt2_i;

    // No request may be consumed while reset is applied or the file waits.
    assign gnt_o = (w_stall || rst) ? '0 : (w_pick1 | w_pick2);

    // Port stages and round-robin pointer. A port that loses keeps its
    // select/data so the file sees stable values with the enable low.
    always_comb begin
        port1_d = port1_q;
        port2_d = port2_q;
        rr_d    = rr_q;
        if (!w_stall) begin
            port1_d.we = w_vld1;
            port2_d.we = w_vld2;
            for (int j = 0; j < NREQ; j++) begin
                if (w_pick1[j]) begin
                    port1_d.idx  = req_dest_i[j*AW +: AW];
                    port1_d.data = req_data_i[j*DW +: DW];
                end
                if (w_pick2[j]) begin
                    port2_d.idx  = req_dest_i[j*AW +: AW];
                    port2_d.data = req_data_i[j*DW +: DW];
                end
                // Port 2 is always later in scan order than port 1, so it is
                // the last grant whenever it is valid.
                if (w_vld2 ? w_pick2[j] : w_pick1[j]) begin
                    rr_d = RRW'((j + 1) % NREQ);
                end
            end
        end
    end

    // Scoreboard: clears from writes leaving the port stages, then the
    // issue-stage set is applied last so it wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (port1_q.we) begin
            busy_d[port1_q.idx] = 1'b0;
        end
        if (port2_q.we) begin
            busy_d[port2_q.idx] = 1'b0;
        end
        if (sb_set_i) begin
            busy_d[sb_set_reg_i] = 1'b1;
        end
        dup_d = dup_q | (sb_set_i & busy_q[sb_set_reg_i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            port1_q <= '0;
            port2_q <= '0;
            busy_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            port1_q <= port1_d;
            port2_q <= port2_d;
            busy_q  <= busy_d;
            dup_q   <= dup_d;
        end
    end

    assign cw1_o     = port1_q.we;
    assign cs1_o     = port1_q.idx;
    assign cd1_o     = port1_q.data;
    assign cw2_o     = port2_q.we;
    assign cs2_o     = port2_q.idx;
    assign cd2_o     = port2_q.data;
    assign sb_busy_o = busy_q;
    assign sb_dup_o  = dup_q;

`ifdef REGWB_CONFLICT_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        w_conflict;

    assign w_conflict = !w_stall && (|(req_i & ~gnt_o));

    always_comb begin
        cnt_d = cnt_q;
        if (conflict_clr_i) begin
            cnt_d = '0;
        end else if (w_conflict && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;
`endif

endmodule : regwb_arbiter
`default_nettype wire

// File: tb/tb_regwb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regwb_arbiter
// Description : Self-checking bench for regwb_arbiter (NREQ=3). A vector
//               table drives requests and states the expected grant and the
//               requester expected on each port; the expected port contents
//               are queued at drive time and compared after the next edge.
//               Hand-written sequences cover stall, scoreboard, mid-run reset
//               and (with REGWB_CONFLICT_CNT_EN) the conflict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regwb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [8:0]  dest;
    logic [47:0] data;
    logic [2:0]  gnt;
    logic        cw1, cw2;
    logic [2:0]  cs1, cs2;
    logic [15:0] cd1, cd2;
    logic        wt1, wt2;
    logic        sb_set;
    logic [2:0]  sb_set_reg;
    logic [7:0]  sb_busy;
    logic        sb_dup;
`ifdef REGWB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
    logic        conflict_clr;
`endif

    always #5 clk = ~clk;

    regwb_arbiter #(.NREQ(3), .DW(16), .AW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .req_dest_i   (dest),
        .req_data_i   (data),
        .gnt_o        (gnt),
        .cw1_o        (cw1),
        .cw2_o        (cw2),
        .cs1_o        (cs1),
        .cs2_o        (cs2),
        .cd1_o        (cd1),
        .cd2_o        (cd2),
        .wt1_i        (wt1),
        .wt2_i        (wt2),
        .sb_set_i     (sb_set),
        .sb_set_reg_i (sb_set_reg),
        .sb_busy_o    (sb_busy),
        .sb_dup_o     (sb_dup)
`ifdef REGWB_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o (conflict_cnt),
        .conflict_clr_i (conflict_clr)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        cw1;
        logic [2:0]  cs1;
        logic [15:0] cd1;
        logic        cw2;
        logic [2:0]  cs2;
        logic [15:0] cd2;
    } exp_t;

    typedef struct {
        logic [2:0] req;
        logic [2:0] d0, d1, d2;
        logic       wt;
        logic [2:0] gnt;
        int         p1;   // requester expected on port 1 (-1 none, -2 hold)
        int         p2;
    } vec_t;

    exp_t q[$];
    exp_t last_exp;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Requester i always offers data 16'hA001 + i.
    task automatic cycle(input logic [2:0] rq, input logic [2:0] d0, input logic [2:0] d1,
                         input logic [2:0] d2, input logic wt, input logic [2:0] eg,
                         input int p1, input int p2, input string nm);
        exp_t       e;
        logic [2:0] dd[3];
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        req  = rq;
        dest = {d2, d1, d0};
        wt1  = wt;
        #4;
        chk({nm, " gnt"}, 32'(gnt), 32'(eg));
        e = last_exp;
        if (p1 != -2) begin
            e.cw1 = (p1 >= 0);
            if (p1 >= 0) begin
                e.cs1 = dd[p1];
                e.cd1 = 16'hA001 + 16'(p1);
            end
        end
        if (p2 != -2) begin
            e.cw2 = (p2 >= 0);
            if (p2 >= 0) begin
                e.cs2 = dd[p2];
                e.cd2 = 16'hA001 + 16'(p2);
            end
        end
        last_exp = e;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({nm, " cw1"}, 32'(cw1), 32'(e.cw1));
        chk({nm, " cs1"}, 32'(cs1), 32'(e.cs1));
        chk({nm, " cd1"}, 32'(cd1), 32'(e.cd1));
        chk({nm, " cw2"}, 32'(cw2), 32'(e.cw2));
        chk({nm, " cs2"}, 32'(cs2), 32'(e.cs2));
        chk({nm, " cd2"}, 32'(cd2), 32'(e.cd2));
    endtask

    // The file must never see both ports writing the same register.
    always @(negedge clk) begin
        if (rst === 1'b0 && cw1 && cw2) begin
            chk("dual same cs", 32'(cs1 == cs2), 32'd0);
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req        = 3'b111;
        dest       = {3'd3, 3'd2, 3'd1};
        data       = {16'hA003, 16'hA002, 16'hA001};
        wt1        = 1'b0;
        wt2        = 1'b0;
        sb_set     = 1'b0;
        sb_set_reg = 3'd0;
`ifdef REGWB_CONFLICT_CNT_EN
        conflict_clr = 1'b0;
`endif
        last_exp = '{default: '0};

        //            req     d0    d1    d2   wt   gnt    p1  p2
        tbl[0] = '{3'b111, 3'd1, 3'd2, 3'd3, 1'b0, 3'b011,  0,  1};
        tbl[1] = '{3'b111, 3'd1, 3'd2, 3'd3, 1'b0, 3'b101,  2,  0};
        tbl[2] = '{3'b111, 3'd1, 3'd2, 3'd3, 1'b0, 3'b110,  1,  2};
        tbl[3] = '{3'b011, 3'd5, 3'd5, 3'd0, 1'b0, 3'b001,  0, -1};
        tbl[4] = '{3'b010, 3'd5, 3'd5, 3'd0, 1'b0, 3'b010,  1, -1};
        tbl[5] = '{3'b100, 3'd0, 3'd0, 3'd0, 1'b0, 3'b100,  2, -1};
        tbl[6] = '{3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1};
        tbl[7] = '{3'b110, 3'd0, 3'd6, 3'd6, 1'b0, 3'b010,  1, -1};
        tbl[8] = '{3'b111, 3'd4, 3'd4, 3'd7, 1'b0, 3'b101,  2,  0};
        tbl[9] = '{3'b101, 3'd2, 3'd0, 3'd2, 1'b0, 3'b100,  2, -1};

        // Reset with every requester active.
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #4;
            chk("rst gnt", 32'(gnt), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("rst cw1", 32'(cw1), 32'd0);
        chk("rst cw2", 32'(cw2), 32'd0);
        chk("rst cs1", 32'(cs1), 32'd0);
        chk("rst cd2", 32'(cd2), 32'd0);
        chk("rst busy", 32'(sb_busy), 32'd0);
        chk("rst dup", 32'(sb_dup), 32'd0);
        rst = 1'b0;

        // Fairness, latency and same-dest skipping.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].wt,
                  tbl[i].gnt, tbl[i].p1, tbl[i].p2, $sformatf("vec%0d", i));
        end

        // Stall: port stages hold, no grants, order resumes afterwards.
        cycle(3'b011, 3'd1, 3'd2, 3'd3, 1'b0, 3'b011, 0, 1, "stall pre");
        for (int i = 0; i < 3; i++) begin
            cycle(3'b111, 3'd1, 3'd2, 3'd3, 1'b1, 3'b000, -2, -2, "stall");
        end
        cycle(3'b111, 3'd1, 3'd2, 3'd3, 1'b0, 3'b101, 2, 0, "stall resume");
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "idle");

        // Scoreboard set / clear / set-wins / duplicate.
        sb_set = 1'b1; sb_set_reg = 3'd4;
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "sb set");
        sb_set = 1'b0;
        chk("sb busy after set", 32'(sb_busy), 32'h10);
        chk("sb dup after set", 32'(sb_dup), 32'd0);
        cycle(3'b001, 3'd4, 3'd0, 3'd0, 1'b0, 3'b001, 0, -1, "wb4");
        chk("sb busy during wb", 32'(sb_busy), 32'h10);
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "wb4 drain");
        chk("sb busy cleared", 32'(sb_busy), 32'h00);
        cycle(3'b001, 3'd4, 3'd0, 3'd0, 1'b0, 3'b001, 0, -1, "wb4b");
        sb_set = 1'b1; sb_set_reg = 3'd4;
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "set+clr");
        sb_set = 1'b0;
        chk("sb set wins", 32'(sb_busy), 32'h10);
        chk("sb no dup", 32'(sb_dup), 32'd0);
        sb_set = 1'b1; sb_set_reg = 3'd4;
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "dup set");
        sb_set = 1'b0;
        chk("sb dup", 32'(sb_dup), 32'd1);
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "dup hold");
        chk("sb dup sticky", 32'(sb_dup), 32'd1);

        // Mid-run reset: rr left at 2, pending write and scoreboard dropped.
        cycle(3'b010, 3'd0, 3'd2, 3'd0, 1'b0, 3'b010, 1, -1, "pre rst");
        rst  = 1'b1;
        req  = 3'b111;
        dest = {3'd3, 3'd2, 3'd1};
        #4;
        chk("midrst gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst cw1", 32'(cw1), 32'd0);
        chk("midrst busy", 32'(sb_busy), 32'd0);
        chk("midrst dup", 32'(sb_dup), 32'd0);
        rst = 1'b0;
        last_exp = '{default: '0};
        cycle(3'b111, 3'd1, 3'd2, 3'd3, 1'b0, 3'b011, 0, 1, "post rst");

`ifdef REGWB_CONFLICT_CNT_EN
        conflict_clr = 1'b1;
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "cnt clr0");
        conflict_clr = 1'b0;
        chk("cnt cleared", 32'(conflict_cnt), 32'd0);
        // rr=2 here: alternating winner between requesters 0 and 1.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                cycle(3'b011, 3'd5, 3'd5, 3'd0, 1'b0, 3'b001, 0, -1, "cnt conf");
            end else begin
                cycle(3'b011, 3'd5, 3'd5, 3'd0, 1'b0, 3'b010, 1, -1, "cnt conf");
            end
        end
        chk("cnt five", 32'(conflict_cnt), 32'd5);
        conflict_clr = 1'b1;
        cycle(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, -1, -1, "cnt clr");
        conflict_clr = 1'b0;
        chk("cnt clr zero", 32'(conflict_cnt), 32'd0);
        req  = 3'b011;
        dest = {3'd0, 3'd5, 3'd5};
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt full", 32'(conflict_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("cnt saturate", 32'(conflict_cnt), 32'hFFFF);
        req = 3'b000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regwb_arbiter
`default_nettype wire
